// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution stage: condition codes, NZCV flag indices and the flag word.
// Optional performance counters in cond_logic are enabled by COND_PERF_CNT_EN.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_eval.sv
// Condition evaluator: maps a 4-bit condition code and stored NZCV flags to an execute decision.
// Purely combinational (zero latency); no flow control. Shared with the branch predictor.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  flags_t     flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            AL: CondEx = 1'b1;
            NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, gates PCSrc/RegWrite/MemWrite by the condition; COND_PERF_CNT_EN adds counters.
// Latency 1 cycle (registered outputs); stall holds outputs/flags, flush clears outputs and blocks flag writes.
module cond_logic
    import cond_pkg::*;
`ifdef COND_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             stall,
    input  logic             flush,
    output logic             valid_out,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags
`ifdef COND_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    flags_t flags_q;
    logic   cond_ex;
    logic   acc;

    // Evaluated against the stored flags so a compare's result is seen by the very next instruction.
    cond_eval u_cond_eval (
        .Cond   (Cond),
        .flags  (flags_q),
        .CondEx (cond_ex)
    );

    assign acc   = valid_in & ~stall & ~flush;
    assign Flags = flags_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (acc && cond_ex) begin
            if (FlagW[1]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Flush outranks stall; a failed condition still occupies a valid slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
        end else if (flush || (!stall && !valid_in)) begin
            valid_out <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
        end else if (!stall) begin
            valid_out <= 1'b1;
            PCSrc     <= PCS & cond_ex;
            RegWrite  <= RegW & cond_ex & ~NoWrite;
            MemWrite  <= MemW & cond_ex;
        end
    end

`ifdef COND_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else if (acc) begin
            if (cond_ex) begin
                exec_cnt <= exec_cnt + 1'b1;
            end else begin
                squash_cnt <= squash_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
